sync_fifo_flags: RTL

Single-clock, parametrised FIFO with a fill-level counter, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. It serves same-clock buffering between pipeline stages, where the dual-clock FIFO's pointer-synchroniser overhead is unnecessary. It adds occupancy reporting, threshold flags, error capture and an optional first-word-fall-through read port.

---
 rtl/sync_fifo_flags_if.sv | 36 +++
 rtl/sync_fifo_flags.sv | 95 +++++++++
 2 files changed

// File: rtl/sync_fifo_flags_if.sv
// sync_fifo_flags_if: write/read/status bundle for sync_fifo_flags.
// master = producer/consumer side, slave = FIFO side.
interface sync_fifo_flags_if #(
  parameter int a_width = 6,
  parameter int d_width = 16
);
  logic               wr_en;
  logic [d_width-1:0] wr_data;
  logic               rd_en;
  logic               err_clr;
  logic [d_width-1:0] rd_data;
  logic               rd_valid;
  logic               fifo_full;
  logic               fifo_empty;
  logic               almost_full;
  logic               almost_empty;
  logic [a_width:0]   fill_count;
  logic               overflow;
  logic               underflow;

  modport master (
    output wr_en, wr_data, rd_en, err_clr,
    input  rd_data, rd_valid,
    input  fifo_full, fifo_empty,
    input  almost_full, almost_empty,
    input  fill_count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, err_clr,
    output rd_data, rd_valid,
    output fifo_full, fifo_empty,
    output almost_full, almost_empty,
    output fill_count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO, fill count, almost flags, sticky errors.
// Ports: Clk, Reset (sync, active-high), bus (slave: wr/rd/err_clr in;
// rd_data, rd_valid, full/empty/almost flags, fill_count, overflow,
// underflow out). Define SYNC_FIFO_FWFT_EN for a fall-through read port.
module sync_fifo_flags #(
  parameter int a_width  = 6,
  parameter int d_width  = 16,
  parameter int af_level = (2**a_width) - 4,
  parameter int ae_level = 4
) (
  input logic              Clk,
  input logic              Reset,
  sync_fifo_flags_if.slave bus
);
  localparam int DEPTH = 2**a_width;
  localparam logic [a_width:0] FULL_C = (a_width+1)'(DEPTH);
  localparam logic [a_width:0] AF_C   = (a_width+1)'(af_level);
  localparam logic [a_width:0] AE_C   = (a_width+1)'(ae_level);

  logic [d_width-1:0] mem [DEPTH];
  logic [a_width-1:0] wr_ptr;
  logic [a_width-1:0] rd_ptr;
  logic [a_width:0]   cnt;
  logic               ovf;
  logic               udf;
  logic               full;
  logic               empty;
  logic               wa;
  logic               ra;

  assign full  = (cnt == FULL_C);
  assign empty = (cnt == '0);
  // a full FIFO still takes a write when the same edge pops
  assign wa = bus.wr_en & (~full | bus.rd_en);
  assign ra = bus.rd_en & ~empty;

  always_ff @(posedge Clk) begin
    if (wa & ~Reset)
      mem[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (wa)
        wr_ptr <= wr_ptr + 1'b1;
      if (ra)
        rd_ptr <= rd_ptr + 1'b1;
      if (wa & ~ra)
        cnt <= cnt + 1'b1;
      else if (ra & ~wa)
        cnt <= cnt - 1'b1;
      // set has priority over clear
      ovf <= (bus.wr_en & full & ~bus.rd_en)
           | (ovf & ~bus.err_clr);
      udf <= (bus.rd_en & empty)
           | (udf & ~bus.err_clr);
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign bus.rd_data  = mem[rd_ptr];
  assign bus.rd_valid = ~empty;
`else
  logic [d_width-1:0] rd_q;
  logic               rv_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_q <= '0;
      rv_q <= 1'b0;
    end else begin
      rv_q <= ra;
      if (ra)
        rd_q <= mem[rd_ptr];
    end
  end

  assign bus.rd_data  = rd_q;
  assign bus.rd_valid = rv_q;
`endif

  assign bus.fifo_full    = full;
  assign bus.fifo_empty   = empty;
  assign bus.almost_full  = (cnt >= AF_C);
  assign bus.almost_empty = (cnt <= AE_C);
  assign bus.fill_count   = cnt;
  assign bus.overflow     = ovf;
  assign bus.underflow    = udf;
endmodule
